// File: rtl/conv_window_buffer_pkg.sv
`default_nettype none
// =============================================================================
// conv_window_buffer_pkg : shared helpers for the KxK sliding-window generator
// Revision : 1.0
// =============================================================================
package conv_window_buffer_pkg;

    localparam int unsigned MIN_K = 2;
    localparam int unsigned MAX_K = 7;

    // Flat element index of window position (r, c); r=0 is the oldest row.
    function automatic int unsigned win_idx(input int unsigned r, input int unsigned c,
                                            input int unsigned k);
        return r * k + c;
    endfunction

    // True when a counter position completes a window that lies on the stride grid.
    function automatic logic stride_hit(input int unsigned idx, input int unsigned k,
                                        input int unsigned stride);
        if (idx < k - 1) begin
            return 1'b0;
        end
        return ((idx - (k - 1)) % stride) == 0;
    endfunction

    // Position of the last window-completing pixel along one axis.
    function automatic int unsigned last_pos(input int unsigned n, input int unsigned k,
                                             input int unsigned stride);
        return (k - 1) + ((n - k) / stride) * stride;
    endfunction

    function automatic logic cfg_legal(input int unsigned img_w, input int unsigned img_h,
                                       input int unsigned k, input int unsigned stride);
        return (k >= MIN_K) && (k <= MAX_K) && ((stride == 1) || (stride == 2)) &&
               (img_w >= k) && (img_h >= k);
    endfunction

endpackage
`default_nettype wire

// File: rtl/conv_window_buffer_line_fifo.sv
`default_nettype none
// =============================================================================
// conv_window_buffer_line_fifo : shift-enable delay line holding one image row
// Revision : 1.0
// =============================================================================
module conv_window_buffer_line_fifo #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 28
) (
    input  logic              clk,
    input  logic              shift_en_i,
    input  logic [DATA_W-1:0] data_i,
    output logic [DATA_W-1:0] data_o
);

    // Newest sample lives in the low slice, oldest in the high slice.
    logic [DEPTH*DATA_W-1:0] mem_q;

    always_ff @(posedge clk) begin
        if (shift_en_i) begin
            mem_q <= {mem_q[(DEPTH-1)*DATA_W-1:0], data_i};
        end
    end

    assign data_o = mem_q[DEPTH*DATA_W-1 -: DATA_W];

endmodule
`default_nettype wire

// File: rtl/conv_window_buffer.sv
`default_nettype none
// =============================================================================
// conv_window_buffer : streaming KxK window generator with stride and frame tracking
// Revision : 1.0
// =============================================================================
module conv_window_buffer
    import conv_window_buffer_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int IMG_W  = 28,
    parameter int IMG_H  = 28,
    parameter int K      = 3,
    parameter int STRIDE = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clear_i,
    input  logic                  in_valid_i,
    output logic                  in_ready_o,
    input  logic [DATA_W-1:0]     in_data_i,
    output logic                  win_valid_o,
    input  logic                  win_ready_i,
    output logic [K*K*DATA_W-1:0] win_data_o,
    output logic                  win_last_o,
    output logic                  frame_done_o
);

    localparam int COL_W = $clog2(IMG_W);
    localparam int ROW_W = $clog2(IMG_H);
    localparam int WIN_W = K * K * DATA_W;

    localparam logic [COL_W-1:0] COL_MAX  = COL_W'(IMG_W - 1);
    localparam logic [ROW_W-1:0] ROW_MAX  = ROW_W'(IMG_H - 1);
    localparam logic [COL_W-1:0] LAST_COL = COL_W'(last_pos(IMG_W, K, STRIDE));
    localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(last_pos(IMG_H, K, STRIDE));

    if (!cfg_legal(IMG_W, IMG_H, K, STRIDE)) begin : g_cfg_check
        $error("conv_window_buffer: illegal K / STRIDE / image size combination");
    end

    logic [COL_W-1:0] col_q, col_d;
    logic [ROW_W-1:0] row_q, row_d;
    logic             win_valid_q, win_valid_d;
    logic             win_last_q, win_last_d;
    logic             frame_done_q, frame_done_d;
    logic [WIN_W-1:0] win_q;

    logic                    w_accept;
    logic                    w_win_hit;
    logic                    w_is_last;
    logic                    w_col_end;
    logic                    w_row_end;
    logic [(K-1)*DATA_W-1:0] w_tap;
    logic [(K-1)*DATA_W-1:0] w_fifo_in;
    logic [K*DATA_W-1:0]     w_newcol;
    logic [WIN_W-1:0]        w_win_next;

    assign in_ready_o = !win_valid_q || win_ready_i;
    // A pixel presented alongside clear is dropped.
    assign w_accept   = in_valid_i && in_ready_o && !clear_i;

    assign w_col_end  = (col_q == COL_MAX);
    assign w_row_end  = (row_q == ROW_MAX);
    assign w_win_hit  = stride_hit(32'(col_q), K, STRIDE) && stride_hit(32'(row_q), K, STRIDE);
    assign w_is_last  = (col_q == LAST_COL) && (row_q == LAST_ROW);

    // Line FIFO j delays by (K-1-j) rows and feeds window row j.
    for (genvar j = 0; j < K - 1; j++) begin : g_line
        if (j == K - 2) begin : g_head
            assign w_fifo_in[j*DATA_W +: DATA_W] = in_data_i;
        end else begin : g_link
            assign w_fifo_in[j*DATA_W +: DATA_W] = w_tap[(j+1)*DATA_W +: DATA_W];
        end

        conv_window_buffer_line_fifo #(
            .DATA_W (DATA_W),
            .DEPTH  (IMG_W)
        ) u_line_fifo (
            .clk        (clk),
            .shift_en_i (w_accept),
            .data_i     (w_fifo_in[j*DATA_W +: DATA_W]),
            .data_o     (w_tap[j*DATA_W +: DATA_W])
        );

        assign w_newcol[j*DATA_W +: DATA_W] = w_tap[j*DATA_W +: DATA_W];
    end
    assign w_newcol[(K-1)*DATA_W +: DATA_W] = in_data_i;

    for (genvar r = 0; r < K; r++) begin : g_wrow
        for (genvar c = 0; c < K; c++) begin : g_wcol
            if (c == K - 1) begin : g_new
                assign w_win_next[win_idx(r, c, K)*DATA_W +: DATA_W] =
                    w_newcol[r*DATA_W +: DATA_W];
            end else begin : g_shift
                assign w_win_next[win_idx(r, c, K)*DATA_W +: DATA_W] =
                    win_q[win_idx(r, c + 1, K)*DATA_W +: DATA_W];
            end
        end
    end

    // Window storage is qualified by win_valid, so it carries no reset.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            win_q <= w_win_next;
        end
    end

    always_comb begin
        col_d        = col_q;
        row_d        = row_q;
        win_valid_d  = win_valid_q;
        win_last_d   = win_last_q;
        frame_done_d = 1'b0;
        if (clear_i) begin
            col_d       = '0;
            row_d       = '0;
            win_valid_d = 1'b0;
            win_last_d  = 1'b0;
        end else if (w_accept) begin
            col_d = w_col_end ? '0 : col_q + COL_W'(1);
            if (w_col_end) begin
                row_d = w_row_end ? '0 : row_q + ROW_W'(1);
            end
            win_valid_d  = w_win_hit;
            win_last_d   = w_win_hit && w_is_last;
            frame_done_d = w_col_end && w_row_end;
        end else if (win_ready_i) begin
            win_valid_d = 1'b0;
            win_last_d  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_q        <= '0;
            row_q        <= '0;
            win_valid_q  <= 1'b0;
            win_last_q   <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            col_q        <= col_d;
            row_q        <= row_d;
            win_valid_q  <= win_valid_d;
            win_last_q   <= win_last_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign win_valid_o  = win_valid_q;
    assign win_last_o   = win_last_q;
    assign frame_done_o = frame_done_q;
    assign win_data_o   = win_valid_q ? win_q : '0;

endmodule
`default_nettype wire

// File: tb/tb_conv_window_buffer.sv
`default_nettype none
// =============================================================================
// tb_conv_window_buffer : directed bench, 5x5 image, K=3, pixel = row*16+col
// Revision : 1.0
// =============================================================================
module tb_conv_window_buffer;

    localparam int DW = 8;
    localparam int IW = 5;
    localparam int IH = 5;
    localparam int KK = 3;
    localparam int WW = KK * KK * DW;
    localparam int NPX = IW * IH;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          clear = 1'b0;
    logic          in_valid = 1'b0;
    logic [DW-1:0] in_data = '0;
    logic          win_ready = 1'b0;

    logic          rdy1, wv1, wl1, fd1;
    logic [WW-1:0] wd1;
    logic          rdy2, wv2, wl2, fd2;
    logic [WW-1:0] wd2;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    conv_window_buffer #(.DATA_W(DW), .IMG_W(IW), .IMG_H(IH), .K(KK), .STRIDE(1)) u_dut_s1 (
        .clk(clk), .rst_n(rst_n), .clear_i(clear), .in_valid_i(in_valid), .in_ready_o(rdy1),
        .in_data_i(in_data), .win_valid_o(wv1), .win_ready_i(win_ready), .win_data_o(wd1),
        .win_last_o(wl1), .frame_done_o(fd1));

    conv_window_buffer #(.DATA_W(DW), .IMG_W(IW), .IMG_H(IH), .K(KK), .STRIDE(2)) u_dut_s2 (
        .clk(clk), .rst_n(rst_n), .clear_i(clear), .in_valid_i(in_valid), .in_ready_o(rdy2),
        .in_data_i(in_data), .win_valid_o(wv2), .win_ready_i(win_ready), .win_data_o(wd2),
        .win_last_o(wl2), .frame_done_o(fd2));

    task automatic chk(input string tag, input logic [WW-1:0] obs, input logic [WW-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] pixel(input int idx);
        return DW'(((idx / IW) * 16) + (idx % IW));
    endfunction

    function automatic logic [WW-1:0] exp_win(input int r0, input int c0);
        logic [WW-1:0] w = '0;
        for (int r = 0; r < KK; r++)
            for (int c = 0; c < KK; c++)
                w[(r*KK+c)*DW +: DW] = DW'((r0 + r) * 16 + c0 + c);
        return w;
    endfunction

    task automatic sample(input bit sel, output logic rdy, output logic wv, output logic wl,
                          output logic fd, output logic [WW-1:0] wd);
        if (sel) begin
            rdy = rdy2; wv = wv2; wl = wl2; fd = fd2; wd = wd2;
        end else begin
            rdy = rdy1; wv = wv1; wl = wl1; fd = fd1; wd = wd1;
        end
    endtask

    // Streams one frame from edge+1; stop_px >= 0 returns once that many pixels are in.
    task automatic run_frame(input bit sel, input int stride, input int gap_pct,
                             input int stall, input int stop_px, input string tag);
        logic [WW-1:0] exp_q[$];
        int            px = 0, widx = 0, stall_left = stall, drain = 0, budget = 0, fd_cnt = 0;
        bit            last_acc = 0, holding = 0;
        logic [WW-1:0] held_d = '0;
        logic          held_l = 1'b0;
        logic          s_rdy, s_wv, s_wl, s_fd;
        logic [WW-1:0] s_wd;

        for (int r0 = 0; r0 <= IH - KK; r0 += stride)
            for (int c0 = 0; c0 <= IW - KK; c0 += stride)
                exp_q.push_back(exp_win(r0, c0));

        while (drain < 4 && budget < 400) begin
            budget++;
            sample(sel, s_rdy, s_wv, s_wl, s_fd, s_wd);
            if (s_fd) fd_cnt++;
            if (last_acc) chk({tag, "_frame_done"}, WW'(s_fd), WW'(1));
            if (holding) begin
                chk({tag, "_hold_data"}, s_wd, held_d);
                chk({tag, "_hold_last"}, WW'(s_wl), WW'(held_l));
            end
            if (stop_px >= 0 && px == stop_px) break;

            win_ready = 1'b1;
            if (s_wv && stall_left > 0) begin
                win_ready = 1'b0;
                stall_left--;
            end
            in_valid = (px < NPX) && ($urandom_range(99) >= gap_pct);
            in_data  = (px < NPX) ? pixel(px) : '0;
            #1;
            sample(sel, s_rdy, s_wv, s_wl, s_fd, s_wd);
            chk({tag, "_in_ready"}, WW'(s_rdy), WW'(!s_wv || win_ready));

            if (s_wv && win_ready) begin
                if (widx < exp_q.size()) begin
                    chk({tag, "_win_data"}, s_wd, exp_q[widx]);
                    chk({tag, "_win_last"}, WW'(s_wl), WW'(widx == exp_q.size() - 1));
                end
                widx++;
            end
            holding  = s_wv && !win_ready;
            held_d   = s_wd;
            held_l   = s_wl;
            last_acc = in_valid && s_rdy && (px == NPX - 1);
            if (in_valid && s_rdy) px++;
            if (px >= NPX) drain++;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        chk({tag, "_budget"}, WW'(budget < 400), WW'(1));
        if (stop_px < 0) begin
            chk({tag, "_win_count"}, WW'(widx), WW'(exp_q.size()));
            chk({tag, "_frame_done_count"}, WW'(fd_cnt), WW'(1));
        end
    endtask

    initial begin
        // Reset state, with win_ready low to show in_ready does not depend on it
        repeat (2) @(posedge clk);
        #1;
        chk("rst_win_valid", WW'(wv1), WW'(0));
        chk("rst_win_last", WW'(wl1), WW'(0));
        chk("rst_frame_done", WW'(fd1), WW'(0));
        chk("rst_win_data", wd1, '0);
        chk("rst_in_ready", WW'(rdy1), WW'(1));
        chk("rst_s2_win_valid", WW'(wv2), WW'(0));
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // 1: stride 1, consumer always ready
        run_frame(1'b0, 1, 0, 0, -1, "t1");

        // 2: stride 2 instance, started from a cleared state
        clear = 1'b1;
        @(posedge clk);
        #1;
        clear = 1'b0;
        run_frame(1'b1, 2, 0, 0, -1, "t2");

        // 3: back-pressure on the first window
        clear = 1'b1;
        @(posedge clk);
        #1;
        clear = 1'b0;
        run_frame(1'b0, 1, 0, 3, -1, "t3");

        // 4: random input gaps, frame follows directly
        run_frame(1'b0, 1, 50, 0, -1, "t4");

        // 5: abort after pixel 0x31; clear wins over the simultaneous 0x32 pixel
        run_frame(1'b0, 1, 0, 0, 17, "t5a");
        clear     = 1'b1;
        in_valid  = 1'b1;
        in_data   = 8'h32;
        win_ready = 1'b1;
        @(posedge clk);
        #1;
        clear    = 1'b0;
        in_valid = 1'b0;
        chk("t5_clear_win_valid", WW'(wv1), WW'(0));
        chk("t5_clear_win_data", wd1, '0);
        run_frame(1'b0, 1, 0, 0, -1, "t5b");

        // 6: asynchronous reset mid-frame while a window is valid
        run_frame(1'b0, 1, 0, 0, 14, "t6a");
        chk("t6_pre_rst_win_valid", WW'(wv1), WW'(1));
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_rst_win_valid", WW'(wv1), WW'(0));
        chk("t6_rst_win_last", WW'(wl1), WW'(0));
        chk("t6_rst_frame_done", WW'(fd1), WW'(0));
        chk("t6_rst_win_data", wd1, '0);
        chk("t6_rst_in_ready", WW'(rdy1), WW'(1));
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        run_frame(1'b0, 1, 0, 0, -1, "t6b");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
